// File: rtl/ed_mon_pkg.sv
// Shared types and width helpers for the adder error-distance monitor family.
// Widths are functions of operand width N and window exponent LOG_WIN.
package ed_mon_pkg;

    localparam int ED_MON_N_DEF       = 16;
    localparam int ED_MON_LOG_WIN_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } ed_mon_state_t;

    // Signed error distance: one bit wider than the N+1 bit sum so it never truncates.
    function automatic int ed_w(input int n);
        return n + 2;
    endfunction

    function automatic int abs_w(input int n);
        return n + 1;
    endfunction

    function automatic int sum_w(input int n, input int log_win);
        return n + 1 + log_win;
    endfunction

    function automatic int bias_w(input int n, input int log_win);
        return n + 2 + log_win;
    endfunction

endpackage

// File: rtl/ed_calc.sv
// Exact sum and error distance of one approximate-adder sample.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Usable by any checker on the A/B/approx-sum interface.
module ed_calc
    import ed_mon_pkg::*;
#(
    parameter int N = ED_MON_N_DEF
) (
    input  logic [N-1:0]            a,
    input  logic [N-1:0]            b,
    input  logic [N:0]              approx,
    output logic [N:0]              exact,
    output logic signed [ed_w(N)-1:0] ed,
    output logic [abs_w(N)-1:0]     abs_ed,
    output logic                    nonzero
);

    localparam int ED_W = ed_w(N);

    logic [ED_W-1:0] ed_neg;

    assign exact   = {1'b0, a} + {1'b0, b};
    assign ed      = $signed({1'b0, exact}) - $signed({1'b0, approx});
    assign ed_neg  = ~ed + ED_W'(1);
    // |ED| peaks at 2^(N+1)-1, so dropping the sign bit is lossless.
    assign abs_ed  = ed[ED_W-1] ? ed_neg[ED_W-2:0] : ed[ED_W-2:0];
    assign nonzero = (ed != '0);

endmodule

// File: rtl/ed_stats_monitor.sv
// Windowed error statistics (count, sum/max/mean |ED|, bias) over 2^LOG_WIN samples.
// Latency: report valid two edges after the last transfer; one sample per cycle sustained.
// Backpressure: in_ready only in RUN; report held until stat_ack or start.
module ed_stats_monitor
    import ed_mon_pkg::*;
#(
    parameter int N       = ED_MON_N_DEF,
    parameter int LOG_WIN = ED_MON_LOG_WIN_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N-1:0]                      in_a,
    input  logic [N-1:0]                      in_b,
    input  logic [N:0]                        in_approx,
    output logic                              stat_valid,
    input  logic                              stat_ack,
    output logic [LOG_WIN:0]                  err_count,
    output logic [sum_w(N, LOG_WIN)-1:0]      sum_abs_ed,
    output logic [N:0]                        max_abs_ed,
    output logic signed [bias_w(N, LOG_WIN)-1:0] bias_sum,
    output logic [N:0]                        mean_abs_ed
);

    localparam int ED_W  = ed_w(N);
    localparam int ABS_W = abs_w(N);
    localparam int SUM_W = sum_w(N, LOG_WIN);

    localparam logic [LOG_WIN:0] WIN_M1 = {1'b0, {LOG_WIN{1'b1}}};

    ed_mon_state_t state, state_nxt;

    logic [N:0]              calc_exact_unused;
    logic signed [ED_W-1:0]  calc_ed;
    logic [ABS_W-1:0]        calc_abs;
    logic                    calc_nz;

    logic [LOG_WIN:0]        cnt;
    logic                    s1_vld;
    logic signed [ED_W-1:0]  s1_ed;
    logic [ABS_W-1:0]        s1_abs;
    logic                    s1_nz;

    logic                    xfer;
    logic                    last_xfer;

    ed_calc #(
        .N(N)
    ) u_calc (
        .a       (in_a),
        .b       (in_b),
        .approx  (in_approx),
        .exact   (calc_exact_unused),
        .ed      (calc_ed),
        .abs_ed  (calc_abs),
        .nonzero (calc_nz)
    );

    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (cnt == WIN_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (last_xfer) state_nxt = DRAIN;
                DRAIN:   state_nxt = REPORT;
                REPORT:  if (stat_ack) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        stat_valid = 1'b0;
        case (state)
            RUN:     in_ready   = 1'b1;
            REPORT:  stat_valid = 1'b1;
            default: ;
        endcase
    end

    // Stage 1 folds into the accumulators on the edge after it loads,
    // so the DRAIN edge absorbs the final sample of the window.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt        <= '0;
            s1_vld     <= 1'b0;
            s1_ed      <= '0;
            s1_abs     <= '0;
            s1_nz      <= 1'b0;
            err_count  <= '0;
            sum_abs_ed <= '0;
            max_abs_ed <= '0;
            bias_sum   <= '0;
        end else begin
            if (s1_vld) begin
                err_count  <= err_count + {{LOG_WIN{1'b0}}, s1_nz};
                sum_abs_ed <= sum_abs_ed + {{LOG_WIN{1'b0}}, s1_abs};
                bias_sum   <= bias_sum + {{LOG_WIN{s1_ed[ED_W-1]}}, s1_ed};
                if (s1_abs > max_abs_ed) begin
                    max_abs_ed <= s1_abs;
                end
            end
            s1_vld <= xfer;
            if (xfer) begin
                s1_ed  <= calc_ed;
                s1_abs <= calc_abs;
                s1_nz  <= calc_nz;
                cnt    <= cnt + (LOG_WIN+1)'(1);
            end
        end
    end

    assign mean_abs_ed = sum_abs_ed[SUM_W-1:LOG_WIN];

endmodule
